// File: rtl/ascon_pkg.sv
// ascon_pkg: shared FSM state type, mode encoding and default operand widths
// for the ASCON serial loader and its interface.
package ascon_pkg;

    localparam int unsigned DEF_K         = 128;
    localparam int unsigned DEF_A_L       = 112;
    localparam int unsigned DEF_TEXT_L    = 128;
    localparam int unsigned NONCE_W       = 128;
    localparam int unsigned TAG_W         = 128;
    localparam int unsigned DEF_START_LEN = 2;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } loader_state_e;

    // Largest of four widths; sets the number of shift steps per load.
    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ascon_serial_loader_if.sv
// ascon_serial_loader_if: serial load bus, core handshake and parallel operand
// bundle between the upstream source, the loader and the ASCON core.
//   slave  : loader side (serial bits / load_start / core_done in, operands out)
//   master : upstream/core side (the reverse)
// Optional LOADER_ABORT_EN adds the abort request line.
interface ascon_serial_loader_if #(
    parameter int unsigned K      = ascon_pkg::DEF_K,
    parameter int unsigned A_L    = ascon_pkg::DEF_A_L,
    parameter int unsigned TEXT_L = ascon_pkg::DEF_TEXT_L
);
    import ascon_pkg::*;

    logic                load_start;
    logic                mode;
    logic                bit_valid;
    logic                key_si;
    logic                nonce_si;
    logic                ad_si;
    logic                text_si;
    logic                tag_si;
    logic                core_done;
`ifdef LOADER_ABORT_EN
    logic                abort;
`endif
    logic [K-1:0]        key;
    logic [NONCE_W-1:0]  nonce;
    logic [A_L-1:0]      associated;
    logic [TEXT_L-1:0]   text;
    logic [TAG_W-1:0]    exp_tag;
    logic                encryption_s;
    logic                decryption_s;
    logic                ready;
    logic                busy;

    modport slave (
        input  load_start, mode, bit_valid, key_si, nonce_si, ad_si, text_si, tag_si, core_done,
`ifdef LOADER_ABORT_EN
        input  abort,
`endif
        output key, nonce, associated, text, exp_tag, encryption_s, decryption_s, ready, busy
    );

    modport master (
        output load_start, mode, bit_valid, key_si, nonce_si, ad_si, text_si, tag_si, core_done,
`ifdef LOADER_ABORT_EN
        output abort,
`endif
        input  key, nonce, associated, text, exp_tag, encryption_s, decryption_s, ready, busy
    );

endinterface

// File: rtl/ascon_sipo_field.sv
// ascon_sipo_field: W-bit serial-in parallel-out register, MSB first.
// Shifts left with si entering the LSB when shift_en is set and step < W,
// so fields narrower than the longest operand stop after W bits.
// Ports: clk, rst (async high), shift_en, step (current shift index), si, q.
module ascon_sipo_field #(
    parameter int unsigned W     = 128,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [CNT_W-1:0] step,
    input  logic             si,
    output logic [W-1:0]     q
);

    logic [W-1:0] field_q;
    logic [W-1:0] field_d;

    always_comb begin
        field_d = field_q;
        if (shift_en && (32'(step) < W)) begin
            field_d = {field_q[W-2:0], si};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) field_q <= '0;
        else     field_q <= field_d;
    end

    assign q = field_q;

endmodule

// File: rtl/ascon_serial_loader.sv
// ascon_serial_loader: deserialises key, nonce, AD, text and expected tag from
// 1-bit MSB-first lines, then pulses the core's encrypt/decrypt start for
// START_LEN cycles and holds the operands until the core reports done.
// Ports: clk, rst (async high), bus (ascon_serial_loader_if.slave).
// Optional: define LOADER_ABORT_EN to add bus.abort (return to IDLE from any
// busy state; operands keep their partial contents).
module ascon_serial_loader
    import ascon_pkg::*;
#(
    parameter int unsigned K         = DEF_K,
    parameter int unsigned A_L       = DEF_A_L,
    parameter int unsigned TEXT_L    = DEF_TEXT_L,
    parameter int unsigned START_LEN = DEF_START_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    ascon_serial_loader_if.slave bus
);

    localparam int unsigned MAX   = max4(K, NONCE_W, A_L, TEXT_L);
    localparam int unsigned CNT_W = $clog2(MAX + 1);

    loader_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             enc_q, enc_d;
    logic             dec_q, dec_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             shift_en;

    // Next state; the counter indexes shift steps in SHIFT and start cycles in START.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    mode_d  = bus.mode;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.bit_valid) begin
                    shift_en = 1'b1;
                    if (cnt_q == CNT_W'(MAX - 1)) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            START: begin
                if (cnt_q == CNT_W'(START_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (bus.core_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef LOADER_ABORT_EN
        // Abort overrides every other transition outside IDLE.
        if (bus.abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            shift_en = 1'b0;
        end
`endif
        // Start outputs follow the next state so they rise on the final shift edge.
        enc_d   = (state_d == START) && (mode_q == MODE_ENC);
        dec_d   = (state_d == START) && (mode_q == MODE_DEC);
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_ENC;
            enc_q   <= 1'b0;
            dec_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            enc_q   <= enc_d;
            dec_q   <= dec_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    ascon_sipo_field #(.W(K), .CNT_W(CNT_W)) u_key (
        .clk(clk), .rst(rst), .shift_en(shift_en), .step(cnt_q), .si(bus.key_si), .q(bus.key)
    );
    ascon_sipo_field #(.W(NONCE_W), .CNT_W(CNT_W)) u_nonce (
        .clk(clk), .rst(rst), .shift_en(shift_en), .step(cnt_q), .si(bus.nonce_si), .q(bus.nonce)
    );
    ascon_sipo_field #(.W(A_L), .CNT_W(CNT_W)) u_ad (
        .clk(clk), .rst(rst), .shift_en(shift_en), .step(cnt_q), .si(bus.ad_si), .q(bus.associated)
    );
    ascon_sipo_field #(.W(TEXT_L), .CNT_W(CNT_W)) u_text (
        .clk(clk), .rst(rst), .shift_en(shift_en), .step(cnt_q), .si(bus.text_si), .q(bus.text)
    );
    ascon_sipo_field #(.W(TAG_W), .CNT_W(CNT_W)) u_tag (
        .clk(clk), .rst(rst), .shift_en(shift_en), .step(cnt_q), .si(bus.tag_si), .q(bus.exp_tag)
    );

    assign bus.encryption_s = enc_q;
    assign bus.decryption_s = dec_q;
    assign bus.ready        = ready_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_ascon_serial_loader.sv
// tb_ascon_serial_loader: randomized bench for ascon_serial_loader with a
// stream-level reference model (bit i of a stream lands at field[W-1-i]).
module tb_ascon_serial_loader;
    import ascon_pkg::*;

    localparam int TB_MAX       = 128;   // widest operand = shift steps per load
    localparam int TB_START_LEN = 2;
    localparam int OPW          = DEF_K + NONCE_W + DEF_A_L + DEF_TEXT_L + TAG_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ascon_serial_loader_if bus ();
    ascon_serial_loader dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;

    // Observations gathered by do_load
    int   obs_enc_first, obs_enc_len, obs_dec_first, obs_dec_len;
    logic obs_both, obs_busy_bad;
    logic [129:0] obs_vec;

    logic [127:0] s1_key, s1_non, s1_ad, s1_txt, s1_tag;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Field of width w after w MSB-first steps of stream s (s[127] is bit 0).
    function automatic logic [127:0] expect_field(input logic [127:0] s, input int w);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[w-1-i] = s[127-i];
        return r;
    endfunction

    function automatic logic [OPW-1:0] model_ops(input logic [127:0] ks, input logic [127:0] ns,
                                                 input logic [127:0] as, input logic [127:0] ts,
                                                 input logic [127:0] gs);
        logic [127:0] k, n, a, t, g;
        k = expect_field(ks, DEF_K);
        n = expect_field(ns, NONCE_W);
        a = expect_field(as, DEF_A_L);
        t = expect_field(ts, DEF_TEXT_L);
        g = expect_field(gs, TAG_W);
        return {k[DEF_K-1:0], n, a[DEF_A_L-1:0], t[DEF_TEXT_L-1:0], g};
    endfunction

    // Start pulse expected TB_MAX + stalls edges after the accept edge.
    function automatic logic [129:0] exp_pulse(input logic m, input int nstall);
        int hit;
        hit = TB_MAX + nstall;
        if (m == MODE_ENC) return {32'(hit), 32'(TB_START_LEN), 32'hFFFF_FFFF, 32'd0, 2'b00};
        else               return {32'hFFFF_FFFF, 32'd0, 32'(hit), 32'(TB_START_LEN), 2'b00};
    endfunction

    function automatic logic [OPW-1:0] dut_ops();
        return {bus.key, bus.nonce, bus.associated, bus.text, bus.exp_tag};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic observe(input int c, input int last_shift);
        if (bus.encryption_s) begin
            if (obs_enc_first < 0) obs_enc_first = c;
            obs_enc_len++;
        end
        if (bus.decryption_s) begin
            if (obs_dec_first < 0) obs_dec_first = c;
            obs_dec_len++;
        end
        if (bus.encryption_s && bus.decryption_s) obs_both = 1'b1;
        if (c < last_shift && (bus.ready || !bus.busy)) obs_busy_bad = 1'b1;
    endtask

    // Full load with nstall single-cycle bit_valid drops; ends in WAIT.
    task automatic do_load(input logic m, input logic [127:0] ks, input logic [127:0] ns,
                           input logic [127:0] as, input logic [127:0] ts,
                           input logic [127:0] gs, input int nstall);
        bit mark[TB_MAX];
        int placed, p, c;
        for (int i = 0; i < TB_MAX; i++) mark[i] = 1'b0;
        placed = 0;
        while (placed < nstall) begin
            p = $urandom_range(1, TB_MAX - 1);
            if (!mark[p]) begin mark[p] = 1'b1; placed++; end
        end
        obs_enc_first = -1; obs_enc_len = 0; obs_dec_first = -1; obs_dec_len = 0;
        obs_both = 1'b0; obs_busy_bad = 1'b0;
        bus.mode = m; bus.load_start = 1'b1; bus.core_done = 1'b0;
        tick();
        c = 0;
        for (int step = 0; step < TB_MAX; step++) begin
            if (mark[step]) begin
                bus.bit_valid = 1'b0;
                {bus.key_si, bus.nonce_si, bus.ad_si, bus.text_si, bus.tag_si} = 5'($urandom);
                {bus.load_start, bus.core_done, bus.mode} = 3'($urandom);
                tick(); c++; observe(c, TB_MAX + nstall);
            end
            bus.bit_valid = 1'b1;
            bus.key_si = ks[127-step]; bus.nonce_si = ns[127-step]; bus.ad_si = as[127-step];
            bus.text_si = ts[127-step]; bus.tag_si = gs[127-step];
            {bus.load_start, bus.core_done, bus.mode} = 3'($urandom);
            tick(); c++; observe(c, TB_MAX + nstall);
        end
        bus.bit_valid = 1'b0; bus.load_start = 1'b0; bus.core_done = 1'b0;
        repeat (TB_START_LEN + 2) begin
            tick(); c++; observe(c, TB_MAX + nstall);
        end
        obs_vec = {32'(obs_enc_first), 32'(obs_enc_len), 32'(obs_dec_first), 32'(obs_dec_len),
                   obs_both, obs_busy_bad};
    endtask

    task automatic release_core();
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({dut_ops(), bus.encryption_s, bus.decryption_s, bus.ready, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got ops=%h enc=%b dec=%b ready=%b busy=%b want all 0",
                     dut_ops(), bus.encryption_s, bus.decryption_s, bus.ready, bus.busy);
        end
        tick(); tick();
        #2 rst = 1'b0;
        tick();
        n_cmp++;
        if ({bus.ready, bus.busy, bus.encryption_s, bus.decryption_s} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_release got ready=%b busy=%b enc=%b dec=%b want 1 0 0 0",
                     bus.ready, bus.busy, bus.encryption_s, bus.decryption_s);
        end
    endtask

    task automatic test_encrypt();
        logic [OPW-1:0] e;
        s1_key = 128'h000102030405060708090A0B0C0D0E0F;
        s1_non = 128'h000102030405060708090A0B0C0D0E0F;
        s1_ad  = {112'h000102030405060708090a0b0c0d, 16'($urandom)};
        s1_txt = 128'h000102030405060708090a0b0c0d0e0f;
        s1_tag = rand128();
        do_load(MODE_ENC, s1_key, s1_non, s1_ad, s1_txt, s1_tag, 0);
        n_cmp++;
        if (obs_vec !== exp_pulse(MODE_ENC, 0)) begin
            n_fail++;
            $display("FAIL enc_pulse got %h want %h", obs_vec, exp_pulse(MODE_ENC, 0));
        end
        e = model_ops(s1_key, s1_non, s1_ad, s1_txt, s1_tag);
        n_cmp++;
        if (dut_ops() !== e) begin
            n_fail++;
            $display("FAIL enc_operands got %h want %h", dut_ops(), e);
        end
        n_cmp++;
        if (bus.associated !== 112'h000102030405060708090a0b0c0d) begin
            n_fail++;
            $display("FAIL enc_ad_truncate got %h want 000102030405060708090a0b0c0d", bus.associated);
        end
        release_core();
        n_cmp++;
        if ({bus.ready, bus.busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL enc_done got ready=%b busy=%b want 1 0", bus.ready, bus.busy);
        end
    endtask

    task automatic test_decrypt();
        logic [127:0] ks, ns, as, ts, gs;
        logic [OPW-1:0] e;
        ks = rand128(); ns = rand128(); as = rand128();
        ts = 128'h2e325340df7fd0bfd25bec2d8a596b44;
        gs = 128'h526e4b15b4b3184a2fc1f7d160e4e972;
        do_load(MODE_DEC, ks, ns, as, ts, gs, 0);
        n_cmp++;
        if (obs_vec !== exp_pulse(MODE_DEC, 0)) begin
            n_fail++;
            $display("FAIL dec_pulse got %h want %h", obs_vec, exp_pulse(MODE_DEC, 0));
        end
        n_cmp++;
        if ({bus.text, bus.exp_tag} !== {ts, gs}) begin
            n_fail++;
            $display("FAIL dec_text_tag got %h %h want %h %h", bus.text, bus.exp_tag, ts, gs);
        end
        e = model_ops(ks, ns, as, ts, gs);
        n_cmp++;
        if (dut_ops() !== e) begin
            n_fail++;
            $display("FAIL dec_operands got %h want %h", dut_ops(), e);
        end
        release_core();
    endtask

    task automatic test_stall();
        logic [OPW-1:0] e;
        do_load(MODE_ENC, s1_key, s1_non, s1_ad, s1_txt, s1_tag, 10);
        n_cmp++;
        if (obs_vec !== exp_pulse(MODE_ENC, 10)) begin
            n_fail++;
            $display("FAIL stall_pulse got %h want %h", obs_vec, exp_pulse(MODE_ENC, 10));
        end
        e = model_ops(s1_key, s1_non, s1_ad, s1_txt, s1_tag);
        n_cmp++;
        if (dut_ops() !== e) begin
            n_fail++;
            $display("FAIL stall_operands got %h want %h", dut_ops(), e);
        end
        release_core();
    endtask

    task automatic test_handshake();
        logic [127:0] ks, ns, as, ts, gs;
        logic [OPW-1:0] e;
        ks = rand128(); ns = rand128(); as = rand128(); ts = rand128(); gs = rand128();
        e = model_ops(ks, ns, as, ts, gs);
        do_load(MODE_ENC, ks, ns, as, ts, gs, 0);
        for (int i = 0; i < 5; i++) begin
            bus.load_start = 1'b1;
            bus.mode = 1'($urandom);
            bus.bit_valid = 1'b1;
            bus.key_si = 1'($urandom);
            tick();
            n_cmp++;
            if ({bus.ready, bus.busy, bus.encryption_s, bus.decryption_s, dut_ops()} !== {4'b0100, e}) begin
                n_fail++;
                $display("FAIL hs_wait_hold cycle %0d got ready=%b busy=%b enc=%b dec=%b ops=%h want 0 1 0 0 ops=%h",
                         i, bus.ready, bus.busy, bus.encryption_s, bus.decryption_s, dut_ops(), e);
            end
        end
        bus.load_start = 1'b0; bus.bit_valid = 1'b0;
        release_core();
        n_cmp++;
        if ({bus.ready, bus.busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL hs_ready_return got ready=%b busy=%b want 1 0", bus.ready, bus.busy);
        end
        tick(); tick(); tick();
        n_cmp++;
        if ({bus.ready, bus.busy, dut_ops()} !== {2'b10, e}) begin
            n_fail++;
            $display("FAIL hs_idle_hold got ready=%b busy=%b ops=%h want 1 0 ops=%h",
                     bus.ready, bus.busy, dut_ops(), e);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [127:0] ks, ns, as, ts, gs;
        logic [OPW-1:0] e;
        bus.mode = MODE_DEC; bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0; bus.bit_valid = 1'b1;
        for (int step = 0; step < 60; step++) begin
            {bus.key_si, bus.nonce_si, bus.ad_si, bus.text_si, bus.tag_si} = 5'($urandom);
            tick();
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({dut_ops(), bus.encryption_s, bus.decryption_s, bus.ready, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_shift got ops=%h enc=%b dec=%b ready=%b busy=%b want all 0",
                     dut_ops(), bus.encryption_s, bus.decryption_s, bus.ready, bus.busy);
        end
        bus.bit_valid = 1'b0;
        tick(); tick();
        #2 rst = 1'b0;
        tick();
        ks = rand128(); ns = rand128(); as = rand128(); ts = rand128(); gs = rand128();
        do_load(MODE_DEC, ks, ns, as, ts, gs, 3);
        n_cmp++;
        if (obs_vec !== exp_pulse(MODE_DEC, 3)) begin
            n_fail++;
            $display("FAIL rst_reload_pulse got %h want %h", obs_vec, exp_pulse(MODE_DEC, 3));
        end
        e = model_ops(ks, ns, as, ts, gs);
        n_cmp++;
        if (dut_ops() !== e) begin
            n_fail++;
            $display("FAIL rst_reload_operands got %h want %h", dut_ops(), e);
        end
        release_core();
    endtask

    task automatic test_back_to_back();
        logic [127:0] ks, ns, as, ts, gs;
        logic [OPW-1:0] e;
        logic m;
        int   n;
        for (int it = 0; it < 4; it++) begin
            m = 1'($urandom);
            n = $urandom_range(0, 6);
            ks = rand128(); ns = rand128(); as = rand128(); ts = rand128(); gs = rand128();
            do_load(m, ks, ns, as, ts, gs, n);
            n_cmp++;
            if (obs_vec !== exp_pulse(m, n)) begin
                n_fail++;
                $display("FAIL b2b_pulse it %0d got %h want %h", it, obs_vec, exp_pulse(m, n));
            end
            e = model_ops(ks, ns, as, ts, gs);
            n_cmp++;
            if (dut_ops() !== e) begin
                n_fail++;
                $display("FAIL b2b_operands it %0d got %h want %h", it, dut_ops(), e);
            end
            release_core();
            n_cmp++;
            if (bus.ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready it %0d got %b want 1", it, bus.ready);
            end
        end
    endtask

`ifdef LOADER_ABORT_EN
    task automatic test_abort();
        logic [127:0] ks, ns, as, ts, gs;
        logic [OPW-1:0] e;
        ks = rand128(); ns = rand128(); as = rand128(); ts = rand128(); gs = rand128();
        e = model_ops(ks, ns, as, ts, gs);
        bus.mode = MODE_ENC; bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0; bus.bit_valid = 1'b1;
        for (int step = 0; step < TB_MAX; step++) begin
            bus.key_si = ks[127-step]; bus.nonce_si = ns[127-step]; bus.ad_si = as[127-step];
            bus.text_si = ts[127-step]; bus.tag_si = gs[127-step];
            tick();
        end
        bus.bit_valid = 1'b0;
        n_cmp++;
        if (bus.encryption_s !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre_start got enc=%b want 1", bus.encryption_s);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_cmp++;
        if ({bus.encryption_s, bus.decryption_s, bus.ready, bus.busy} !== 4'b0010) begin
            n_fail++;
            $display("FAIL abort_idle got enc=%b dec=%b ready=%b busy=%b want 0 0 1 0",
                     bus.encryption_s, bus.decryption_s, bus.ready, bus.busy);
        end
        n_cmp++;
        if (dut_ops() !== e) begin
            n_fail++;
            $display("FAIL abort_operands got %h want %h", dut_ops(), e);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.load_start = 1'b0; bus.mode = 1'b0; bus.bit_valid = 1'b0;
        bus.key_si = 1'b0; bus.nonce_si = 1'b0; bus.ad_si = 1'b0;
        bus.text_si = 1'b0; bus.tag_si = 1'b0; bus.core_done = 1'b0;
`ifdef LOADER_ABORT_EN
        bus.abort = 1'b0;
`endif
        test_reset();
        test_encrypt();
        test_decrypt();
        test_stall();
        test_handshake();
        test_reset_mid_shift();
        test_back_to_back();
`ifdef LOADER_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ascon_serial_loader.md
Name: ascon_serial_loader

Overview:
- Upstream input stage for the ASCON AEAD processing core.
- Deserialises key, nonce, associated data, plaintext/ciphertext and expected tag from 1-bit serial lines, MSB first, into parallel registers that drive the core's operand inputs.
- Issues the core's encryption_s/decryption_s start pulse, then holds operands stable until the core reports completion.

Parameters:
K, 128, key width in bits
A_L, 112, associated-data width in bits
TEXT_L, 128, plaintext/ciphertext width in bits
START_LEN, 2, cycles encryption_s/decryption_s is held high
MAX (localparam), max(K, 128, A_L, TEXT_L), number of shift steps per load

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
load_start  in  1  request a new load; accepted only in IDLE
mode  in  1  0 = encrypt, 1 = decrypt; sampled when load_start is accepted
bit_valid  in  1  serial bits valid this cycle
key_si  in  1  key serial bit
nonce_si  in  1  nonce serial bit
ad_si  in  1  associated-data serial bit
text_si  in  1  plaintext/ciphertext serial bit
tag_si  in  1  expected-tag serial bit (decrypt)
core_done  in  1  encryption_r OR decryption_r from the core
key  out  K  parallel key to core
nonce  out  128  parallel nonce to core
associated  out  A_L  parallel AD to core
text  out  TEXT_L  parallel PT/CT to core
exp_tag  out  128  expected tag to core
encryption_s  out  1  core encrypt start
decryption_s  out  1  core decrypt start
ready  out  1  high only in IDLE
busy  out  1  high in SHIFT, START, WAIT

Behaviour:
- Reset (async, any state): every output register and the counter clear to 0; mode latch clears to 0; FSM goes to IDLE; ready=1 and busy=0 after release.
- FSM states:
  - IDLE: load_start=1 -> latch mode, clear counter, go to SHIFT. Operand registers keep their old values; they are not cleared.
  - SHIFT: on each cycle with bit_valid=1, step i = counter value. Each field F of width W shifts left by one with the serial bit into the LSB, but only while i < W. Counter increments.
  - SHIFT outcome: after W steps, serial bit i of F sits at F[W-1-i]. bit_valid=0 stalls; nothing changes. When the counter reaches MAX-1 with bit_valid=1, go to START next cycle.
  - START: the start output selected by the latched mode is high for exactly START_LEN cycles. A start-cycle counter is reused from the shift counter. Then go to WAIT.
  - WAIT: core_done=1 -> IDLE next cycle.
- Start output is registered: it rises the first cycle after the final shift edge.
- Latency: load_start accepted -> first shift possible the next cycle. Minimum total to start = 1 + MAX cycles.
- Operand outputs are constant from entry to START until return to IDLE.
- load_start outside IDLE is ignored. Serial inputs outside SHIFT are ignored.
- core_done during SHIFT or START is ignored.
- Counter width is $clog2(MAX+1) and never wraps; terminal compare is at MAX-1.
- The encrypt and decrypt start outputs are never high together.

Optional Feature:
- Macro LOADER_ABORT_EN.
- Defined: adds input abort (1 bit). abort=1 in SHIFT, START or WAIT -> IDLE next cycle. The counter clears and both start outputs drop immediately on that edge. Operand registers keep their partial contents. abort has priority over all transitions and is ignored in IDLE.
- Undefined: no abort port; a load can only be terminated by rst.

Decomposition:
- Shared package ascon_pkg holds:
  - FSM state enum: IDLE, SHIFT, START, WAIT (2-bit)
  - mode constants: MODE_ENC=0, MODE_DEC=1
  - default widths: K, A_L, TEXT_L, nonce/tag width 128
- One natural sub-module, ascon_sipo_field: parameterised width W, with shift enable, active-while-count<W gate, and async reset. Instantiated five times.

Test Plan:
1. Encrypt load:
   - Stimulus: mode=0, stream KEY=000102030405060708090A0B0C0D0E0F, NONCE=same, AD=000102030405060708090a0b0c0d, PT=000102030405060708090a0b0c0d0e0f; MAX=128 bits with bit_valid held 1.
   - Response: key/nonce/associated/text equal those values; encryption_s high for exactly 2 cycles starting 129 cycles after load_start; decryption_s stays 0.
2. Decrypt load:
   - Stimulus: mode=1, text=2e325340df7fd0bfd25bec2d8a596b44, tag=526e4b15b4b3184a2fc1f7d160e4e972.
   - Response: exp_tag and text match; only decryption_s pulses.
3. Stall:
   - Stimulus: drop bit_valid for 10 random single cycles during SHIFT.
   - Response: same final registers as scenario 1; start delayed by exactly 10 cycles.
4. Handshake:
   - Stimulus: load_start during WAIT, then core_done=1 for one cycle.
   - Response: ignored until IDLE; ready returns to 1 one cycle after core_done; operands held throughout WAIT.
5. Reset mid-SHIFT:
   - Stimulus: assert rst asynchronously at step 60.
   - Response: all outputs 0 immediately; a subsequent full load produces correct values.
6. LOADER_ABORT_EN:
   - Stimulus: abort during the START first cycle.
   - Response: encryption_s low next edge; state IDLE; ready=1.
